uart_frame_rx: RTL
==================

# uart_frame_rx

Framed-packet receiver sitting directly downstream of the `uart` receiver. It consumes the byte strobe (`new_value` / `recvd_data`), hunts for a header byte, and validates length and XOR checksum. Valid payloads are buffered in an internal byte RAM and held for the consumer (network input loader or command decoder) until acknowledged. Malformed, truncated or timed-out frames are discarded with an error code.

## Interface
Parameters:
- `MAX_LEN`, 16: maximum payload bytes per frame (1..255); buffer depth.
- `HEADER`, 8'hA5: start-of-frame byte.
- `TIMEOUT_CYCLES`, 12000: maximum idle clocks between bytes inside a frame (1 ms at 12 MHz).

Ports (LW = $clog2(MAX_LEN+1), AW = $clog2(MAX_LEN)):
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `new_value`  in  1  one-cycle strobe from uart: `recvd_data` is valid.
- `recvd_data`  in  8  received byte.
- `uart_error`  in  1  uart framing error flag.
- `frame_valid`  out  1  level; a validated frame is held in the buffer.
- `frame_len`  out  LW  payload length of the held frame.
- `frame_ack`  in  1  one-cycle pulse; consumer releases the frame.
- `rd_addr`  in  AW  buffer read address.
- `rd_data`  out  8  registered buffer read data.
- `frame_error`  out  1  one-cycle pulse; a frame was discarded.
- `err_code`  out  2  cause of last discard: 01 bad length, 10 bad checksum, 11 timeout or uart error; holds until the next error.
- `overrun`  out  1  one-cycle pulse; a byte was dropped while in HOLD.
- `busy`  out  1  high in LEN, PAYLOAD, CHECK.

## Operation
- Frame format: `HEADER`, `LEN`, `LEN` payload bytes, `CHK`. `CHK` = XOR of `LEN` and all payload bytes.
- FSM states: IDLE, LEN, PAYLOAD, CHECK, HOLD.
- IDLE: on a strobe, byte == `HEADER` moves to LEN; any other byte is silently ignored.
- LEN: a strobe with byte 0 or byte > `MAX_LEN` pulses error 01 and returns to IDLE. Otherwise latch the length, set cnt = 0 and chk = byte, then go to PAYLOAD.
- PAYLOAD: each strobe writes buf[cnt] = byte, sets chk ^= byte and increments cnt. The strobe that makes cnt == len goes to CHECK.
- CHECK: on a strobe, byte == chk moves to HOLD. A mismatch pulses error 10 and returns to IDLE.
- HOLD: `frame_valid` = 1 and buffer contents and `frame_len` are frozen. Strobes are dropped and each pulses `overrun`. `frame_ack` returns to IDLE.
- Timeout: in LEN, PAYLOAD and CHECK, an idle counter resets on every strobe. When it reaches `TIMEOUT_CYCLES` it pulses error 11 and returns to IDLE.
- `uart_error` high in LEN, PAYLOAD or CHECK pulses error 11 and returns to IDLE. It is ignored in IDLE and HOLD.
- A header byte received mid-frame is treated as data; there is no resync.
- `frame_ack` outside HOLD is ignored.

## Timing
- Reset: state IDLE; `frame_valid`, `frame_len`, `rd_data`, `frame_error`, `err_code`, `overrun` and `busy` all 0; counters cleared. Buffer contents are undefined and never exposed. A reset mid-frame or in HOLD discards the frame.
- `frame_valid` rises on the cycle after the strobe carrying a correct `CHK`.
- `frame_error` pulses exactly one cycle, the cycle after the offending strobe, timeout expiry or `uart_error`. `err_code` updates on that same edge.
- `frame_valid` falls on the cycle after `frame_ack`. A header strobe on that following cycle is accepted.
- If `frame_ack` and a strobe arrive in the same cycle in HOLD, the byte is dropped with `overrun`.
- `rd_data` has 1-cycle latency from `rd_addr`. Reads during HOLD return the held payload. Addresses ≥ `frame_len` return don't-care.
- Buffer writes occur on the strobe cycle. The buffer is only written outside HOLD.
- Throughput: strobes may arrive on consecutive cycles and are all processed.

## Test plan
- Good frame: `A5 03 11 22 33 03` → `frame_valid` = 1 one cycle after the last strobe, `frame_len` = 3, reads 0..2 return 11, 22, 33, no error. After `frame_ack`, `frame_valid` = 0 next cycle.
- Leading garbage: `00 FF A5 01 7E 7F` → valid frame, len 1, buf[0] = 7E.
- Bad checksum: `A5 02 10 20 04` (expected 32) → `frame_error` pulse, `err_code` = 10, `frame_valid` stays 0. A following good frame is then accepted.
- Bad length: `A5 00`, and `A5 11` with `MAX_LEN` = 16 → `frame_error`, `err_code` = 01, back to IDLE.
- Timeout: `A5 02 10` then silence → `frame_error` with `err_code` = 11 exactly `TIMEOUT_CYCLES` clocks after the 10 strobe. Also `uart_error` asserted mid-payload → `err_code` = 11.
- Overrun/ack race: in HOLD send `A5` twice, once coincident with `frame_ack` → two `overrun` pulses, held payload unchanged until ack. A new frame sent after ack is received correctly. A reset asserted in HOLD clears `frame_valid` next cycle.

Source files
------------

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: hunts for a header byte, checks length and XOR checksum, and holds
// the validated payload in a byte buffer until the consumer acknowledges it.
module uart_frame_rx #(
    parameter int          MAX_LEN        = 16,
    parameter logic [7:0]  HEADER         = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 12000,
    localparam int         LW             = $clog2(MAX_LEN + 1),
    localparam int         AW             = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          new_value,
    input  logic [7:0]    recvd_data,
    input  logic          uart_error,
    output logic          frame_valid,
    output logic [LW-1:0] frame_len,
    input  logic          frame_ack,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          frame_error,
    output logic [1:0]    err_code,
    output logic          overrun,
    output logic          busy
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHECK, S_HOLD} state_t;

    state_t        r_state;
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_cnt;
    logic [7:0]    r_chk;
    logic [TW-1:0] r_idle;
    logic          r_frame_error;
    logic [1:0]    r_err_code;
    logic          r_overrun;
    logic [7:0]    r_rd_data;
    logic [7:0]    r_buf [MAX_LEN];

    logic w_timeout;
    assign w_timeout = !new_value && (r_idle == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_len         <= '0;
            r_cnt         <= '0;
            r_chk         <= '0;
            r_idle        <= '0;
            r_frame_error <= 1'b0;
            r_err_code    <= 2'b00;
            r_overrun     <= 1'b0;
        end else begin
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_idle <= '0;
                    if (new_value && recvd_data == HEADER) r_state <= S_LEN;
                end
                S_HOLD: begin
                    r_overrun <= new_value;
                    if (frame_ack) r_state <= S_IDLE;
                end
                default: begin
                    // idle counter restarts on every strobe; expiry lands TIMEOUT_CYCLES clocks after it
                    r_idle <= new_value ? '0 : r_idle + TW'(1);
                    if (uart_error || w_timeout) begin
                        r_state       <= S_IDLE;
                        r_frame_error <= 1'b1;
                        r_err_code    <= 2'b11;
                    end else if (new_value) begin
                        if (r_state == S_LEN) begin
                            if (recvd_data == 8'd0 || recvd_data > 8'(MAX_LEN)) begin
                                r_state       <= S_IDLE;
                                r_frame_error <= 1'b1;
                                r_err_code    <= 2'b01;
                            end else begin
                                r_len   <= LW'(recvd_data);
                                r_cnt   <= '0;
                                r_chk   <= recvd_data;
                                r_state <= S_PAYLOAD;
                            end
                        end else if (r_state == S_PAYLOAD) begin
                            r_chk <= r_chk ^ recvd_data;
                            r_cnt <= r_cnt + LW'(1);
                            if (r_cnt + LW'(1) == r_len) r_state <= S_CHECK;
                        end else if (recvd_data == r_chk) begin
                            r_state <= S_HOLD;
                        end else begin
                            r_state       <= S_IDLE;
                            r_frame_error <= 1'b1;
                            r_err_code    <= 2'b10;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_PAYLOAD && new_value) r_buf[r_cnt[AW-1:0]] <= recvd_data;
    end

    always_ff @(posedge clk) begin
        r_rd_data <= rst ? 8'd0 : r_buf[rd_addr];
    end

    assign frame_valid = (r_state == S_HOLD);
    assign frame_len   = r_len;
    assign rd_data     = r_rd_data;
    assign frame_error = r_frame_error;
    assign err_code    = r_err_code;
    assign overrun     = r_overrun;
    assign busy        = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CHECK);
endmodule
